// File: rtl/bcd_countdown_timer_pkg.sv
// Shared state encoding, BCD digit constants and load sanitising helper for the countdown timer.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Clamp a non-decimal nibble (A-F) to 9 so count always holds legal BCD.
    function automatic logic [3:0] sanitize_digit(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counter: decrements on borrow_in, wraps 0->9 and propagates the borrow.
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit_c,
    output logic       borrow_out_c
);

    // Decrement this digit when the lower digits requested a borrow.
    always_comb begin
        next_digit_c = digit;
        borrow_out_c = 1'b0;
        if (borrow_in) begin
            if (digit == BCD_ZERO) begin
                next_digit_c = BCD_MAX;
                borrow_out_c = 1'b1;
            end else begin
                next_digit_c = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with load/start/stop control, optional auto-reload and expiry pulse.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 2,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    en,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    busy,
    output logic                    zero,
    output logic                    done
);

    localparam int unsigned W = 4 * NUM_DIGITS;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   reload_q, reload_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [W-1:0]          load_san;
    logic [W-1:0]          count_dec;
    logic [NUM_DIGITS:0]   borrow;
    logic                  count_is_one;

    // The chain is seeded with a constant decrement request, so a borrow out of
    // the top digit means every digit was zero: that is exactly the zero flag.
    assign borrow[0] = 1'b1;

    genvar i;
    for (i = 0; i < int'(NUM_DIGITS); i++) begin : g_digit
        assign load_san[4*i +: 4] = sanitize_digit(load_val[4*i +: 4]);

        bcd_digit_down u_digit (
            .digit        (count_q[4*i +: 4]),
            .borrow_in    (borrow[i]),
            .next_digit_c (count_dec[4*i +: 4]),
            .borrow_out_c (borrow[i+1])
        );
    end

    assign zero         = borrow[NUM_DIGITS];
    assign count_is_one = (count_q == W'(1));

    // Next-state logic: load > stop > start > en tick, evaluated per state.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            count_d  = load_san;
            reload_d = load_san;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (en && !zero) begin
                        if (count_is_one) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_EXPIRED;
                            end
                        end else begin
                            count_d = count_dec;
                        end
                    end
                end
                ST_EXPIRED: begin
                    state_d = ST_EXPIRED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: one-shot and auto-reload timers driven in parallel against an integer model.
module tb_bcd_countdown_timer;

    localparam int unsigned ND = 2;
    localparam int unsigned W  = 4 * ND;

    logic         clk = 1'b0;
    logic         rst, load, start, stop, en;
    logic [W-1:0] load_val;
    logic [W-1:0] count0, count1;
    logic         busy0, busy1, zero0, zero1, done0, done1;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_DIGITS(ND), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .en(en), .count(count0), .busy(busy0), .zero(zero0), .done(done0)
    );

    bcd_countdown_timer #(.NUM_DIGITS(ND), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .en(en), .count(count1), .busy(busy1), .zero(zero1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: count as a plain integer, state as 0=idle 1=run 2=expired.
    int m_cnt[2]  = '{0, 0};
    int m_rel[2]  = '{0, 0};
    int m_st[2]   = '{0, 0};
    bit m_done[2] = '{1'b0, 1'b0};
    bit m_valid   = 1'b0;

    function automatic int san_val(input logic [W-1:0] v);
        int r = 0;
        int p = 1;
        for (int k = 0; k < int'(ND); k++) begin
            int d = int'(v[4*k +: 4]);
            if (d > 9) d = 9;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int k = 0; k < int'(ND); k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on every rising edge from the same inputs the DUTs see.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit nd;
            nd = 1'b0;
            if (rst) begin
                m_cnt[k] = 0; m_rel[k] = 0; m_st[k] = 0;
            end else if (load) begin
                m_cnt[k] = san_val(load_val); m_rel[k] = m_cnt[k]; m_st[k] = 0;
            end else if (m_st[k] == 1) begin
                if (stop) begin
                    m_st[k] = 0;
                end else if (en && m_cnt[k] > 0) begin
                    if (m_cnt[k] == 1) begin
                        nd = 1'b1;
                        if (k == 1) begin
                            m_cnt[k] = m_rel[k];
                        end else begin
                            m_cnt[k] = 0;
                            m_st[k]  = 2;
                        end
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
            end else if (m_st[k] == 0 && start && m_cnt[k] != 0) begin
                m_st[k] = 1;
            end
            m_done[k] = nd;
        end
        if (rst) m_valid = 1'b1;
    end

    // Compare both DUTs against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            cmp("count0", 32'(count0), 32'(to_bcd(m_cnt[0])));
            cmp("busy0",  32'(busy0),  32'(m_st[0] == 1));
            cmp("zero0",  32'(zero0),  32'(m_cnt[0] == 0));
            cmp("done0",  32'(done0),  32'(m_done[0]));
            cmp("count1", 32'(count1), 32'(to_bcd(m_cnt[1])));
            cmp("busy1",  32'(busy1),  32'(m_st[1] == 1));
            cmp("zero1",  32'(zero1),  32'(m_cnt[1] == 0));
            cmp("done1",  32'(done1),  32'(m_done[1]));
        end
    end

    int d0 = 0;
    int d1 = 0;

    // One clock with the given inputs; returns at the following falling edge.
    task automatic step(input bit l, input logic [W-1:0] lv, input bit s, input bit sp, input bit e);
        load = l; load_val = lv; start = s; stop = sp; en = e;
        @(negedge clk);
        if (done0) d0++;
        if (done1) d1++;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0; en = 1'b0;
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        rst = 1'b0;
        cmp("lit_rst_count", 32'(count0), 32'h00);
        cmp("lit_rst_zero",  32'(zero0),  32'h1);
        cmp("lit_rst_busy",  32'(busy0),  32'h0);

        step(1, 8'h25, 0, 0, 0);
        cmp("lit_load25", 32'(count0), 32'h25);

        // One-shot countdown from 12 with en held.
        step(1, 8'h12, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        d0 = 0;
        for (int i = 0; i < 13; i++) begin
            step(0, 8'h00, 0, 0, 1);
            if (i == 2) cmp("lit_borrow_09", 32'(count0), 32'h09);
        end
        cmp("lit_oneshot_done", 32'(d0), 32'd1);
        cmp("lit_oneshot_cnt",  32'(count0), 32'h00);
        step(0, 8'h00, 1, 0, 0);
        cmp("lit_expired_start", 32'(busy0), 32'h0);

        // Gated enable: expiry after five en-qualified cycles.
        step(1, 8'h05, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        d0 = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 8'h00, 0, 0, (i % 2) == 0);
            if (i == 7) cmp("lit_gated_nodone", 32'(d0), 32'd0);
        end
        cmp("lit_gated_done", 32'(d0), 32'd1);

        // Stop at 03, then resume to zero.
        step(1, 8'h05, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 1, 1);
        cmp("lit_stop_cnt",  32'(count0), 32'h03);
        cmp("lit_stop_busy", 32'(busy0),  32'h0);
        step(0, 8'h00, 1, 0, 0);
        d0 = 0;
        repeat (4) step(0, 8'h00, 0, 0, 1);
        cmp("lit_resume_cnt",  32'(count0), 32'h00);
        cmp("lit_resume_done", 32'(d0), 32'd1);

        // Auto-reload from 03: done every third tick.
        step(1, 8'h03, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        d1 = 0;
        repeat (9) step(0, 8'h00, 0, 0, 1);
        cmp("lit_ar_done", 32'(d1), 32'd3);
        cmp("lit_ar_busy", 32'(busy1), 32'h1);
        cmp("lit_ar_cnt",  32'(count1), 32'h03);

        // Auto-reload with reload value 1: done on every en cycle.
        step(1, 8'h01, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        d1 = 0;
        repeat (4) step(0, 8'h00, 0, 0, 1);
        cmp("lit_ar1_done", 32'(d1), 32'd4);
        step(0, 8'h00, 0, 1, 0);

        step(1, 8'hA7, 0, 0, 0);
        cmp("lit_sanitize", 32'(count0), 32'h97);

        step(1, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        cmp("lit_zero_start0", 32'(busy0), 32'h0);
        cmp("lit_zero_start1", 32'(busy1), 32'h0);

        step(1, 8'h4F, 1, 0, 0);
        cmp("lit_load_start_cnt",  32'(count0), 32'h49);
        cmp("lit_load_start_busy", 32'(busy0),  32'h0);

        // Stop coincident with the expiry tick.
        step(1, 8'h02, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        d0 = 0;
        step(0, 8'h00, 0, 1, 1);
        cmp("lit_stop_exp_cnt",  32'(count0), 32'h01);
        cmp("lit_stop_exp_done", 32'(d0), 32'd0);
        cmp("lit_stop_exp_busy", 32'(busy0), 32'h0);

        // Reset in the middle of a run.
        step(1, 8'h50, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        repeat (3) step(0, 8'h00, 0, 0, 1);
        rst = 1'b1;
        step(0, 8'h00, 0, 0, 1);
        rst = 1'b0;
        cmp("lit_rst_run_cnt",  32'(count0), 32'h00);
        cmp("lit_rst_run_busy", 32'(busy0),  32'h0);
        cmp("lit_rst_run_done", 32'(done0),  32'h0);
        step(0, 8'h00, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
